// File: rtl/demux_destino.sv
`default_nettype none
// ============================================================================
//  Module      : demux_destino
//  Description : Receive-side destination demultiplexer. Routes each word of
//                the arbiter output stream to FIFO D0 or D1 according to
//                data[DEST_BIT]. A 2-entry skid buffer absorbs upstream pop
//                latency while a destination is almost full. Global word
//                order is preserved (a blocked head also blocks the other
//                destination).
//  Ports       : clk, reset (async, active-high)
//                data_in/valid_in            : word stream from arbiter mux
//                D0_almost_full/D1_almost_full : destination backpressure
//                push_Dx/data_out_Dx         : registered push + word per dest
//                pause                       : registered stop-popping request
//                count_Dx                    : wrapping delivered-word counters
//                err_overflow                : sticky, a word was dropped
//                idle                        : buffer empty and no push issued
//  Revision    : 1.0  initial release
// ============================================================================
module demux_destino #(
    parameter int DATA_WIDTH = 6,
    parameter int DEST_BIT   = 4,
    parameter int CNT_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid_in,
    input  logic                  D0_almost_full,
    input  logic                  D1_almost_full,
    output logic                  push_D0,
    output logic                  push_D1,
    output logic [DATA_WIDTH-1:0] data_out_D0,
    output logic [DATA_WIDTH-1:0] data_out_D1,
    output logic                  pause,
    output logic [CNT_WIDTH-1:0]  count_D0,
    output logic [CNT_WIDTH-1:0]  count_D1,
    output logic                  err_overflow,
    output logic                  idle
);

    // Buffer occupancy encoding
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } occ_t;

    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE = 1;

    occ_t                  r_occ;
    logic [DATA_WIDTH-1:0] r_head;
    logic [DATA_WIDTH-1:0] r_tail;
    logic                  r_push_d0;
    logic                  r_push_d1;
    logic [DATA_WIDTH-1:0] r_data_d0;
    logic [DATA_WIDTH-1:0] r_data_d1;
    logic                  r_pause;
    logic [CNT_WIDTH-1:0]  r_count_d0;
    logic [CNT_WIDTH-1:0]  r_count_d1;
    logic                  r_err;

    logic                  w_buf_nonempty;
    logic                  w_cand_valid;
    logic [DATA_WIDTH-1:0] w_cand;
    logic                  w_cand_dest;
    logic                  w_target_af;
    logic                  w_send;
    logic                  w_arrival;
    occ_t                  w_occ_next;

    // Candidate selection: the buffer head always has priority over data_in
    // so that global order is kept.
    assign w_buf_nonempty = (r_occ != S_EMPTY);
    assign w_cand_valid   = w_buf_nonempty | valid_in;
    assign w_cand         = w_buf_nonempty ? r_head : data_in;
    assign w_cand_dest    = w_cand[DEST_BIT];
    assign w_target_af    = w_cand_dest ? D1_almost_full : D0_almost_full;
    assign w_send         = w_cand_valid & ~w_target_af;
    // data_in that is not itself the candidate must be appended behind it
    assign w_arrival      = valid_in & w_buf_nonempty;

    always_comb begin
        w_occ_next = r_occ;
        case (r_occ)
            S_EMPTY: begin
                if (valid_in && !w_send) w_occ_next = S_ONE;
            end
            S_ONE: begin
                if (w_send && !w_arrival)      w_occ_next = S_EMPTY;
                else if (!w_send && w_arrival) w_occ_next = S_TWO;
                else                           w_occ_next = S_ONE;
            end
            S_TWO: begin
                if (w_send && !w_arrival) w_occ_next = S_ONE;
                else                      w_occ_next = S_TWO;
            end
            default: w_occ_next = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_occ      <= S_EMPTY;
            r_head     <= '0;
            r_tail     <= '0;
            r_push_d0  <= 1'b0;
            r_push_d1  <= 1'b0;
            r_data_d0  <= '0;
            r_data_d1  <= '0;
            r_pause    <= 1'b0;
            r_count_d0 <= '0;
            r_count_d1 <= '0;
            r_err      <= 1'b0;
        end else begin
            r_occ     <= w_occ_next;
            r_pause   <= (w_occ_next != S_EMPTY);
            r_push_d0 <= w_send & ~w_cand_dest;
            r_push_d1 <= w_send &  w_cand_dest;

            if (w_send && !w_cand_dest) begin
                r_data_d0  <= w_cand;
                r_count_d0 <= r_count_d0 + c_CNT_ONE;
            end
            if (w_send && w_cand_dest) begin
                r_data_d1  <= w_cand;
                r_count_d1 <= r_count_d1 + c_CNT_ONE;
            end

            // Buffer storage moves
            case (r_occ)
                S_EMPTY: begin
                    if (valid_in && !w_send) r_head <= data_in;
                end
                S_ONE: begin
                    if (w_send && w_arrival)       r_head <= data_in;
                    else if (!w_send && w_arrival) r_tail <= data_in;
                end
                S_TWO: begin
                    if (w_send) begin
                        // Head leaves; tail advances and any arrival refills the tail
                        r_head <= r_tail;
                        if (w_arrival) r_tail <= data_in;
                    end else if (w_arrival) begin
                        // No room: arriving word is dropped
                        r_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign push_D0      = r_push_d0;
    assign push_D1      = r_push_d1;
    assign data_out_D0  = r_data_d0;
    assign data_out_D1  = r_data_d1;
    assign pause        = r_pause;
    assign count_D0     = r_count_d0;
    assign count_D1     = r_count_d1;
    assign err_overflow = r_err;
    assign idle         = (r_occ == S_EMPTY) & ~r_push_d0 & ~r_push_d1;

endmodule
`default_nettype wire

// File: tb/tb_demux_destino.sv
`default_nettype none
// ============================================================================
//  Module      : tb_demux_destino
//  Description : Scoreboard testbench for demux_destino. Stimulus pushes the
//                expected (word, count) per destination into queues; a
//                negedge monitor pops and compares on every push strobe.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_demux_destino;

    logic       clk;
    logic       reset;
    logic [5:0] data_in;
    logic       valid_in;
    logic       D0_almost_full;
    logic       D1_almost_full;
    logic       push_D0;
    logic       push_D1;
    logic [5:0] data_out_D0;
    logic [5:0] data_out_D1;
    logic       pause;
    logic [4:0] count_D0;
    logic [4:0] count_D1;
    logic       err_overflow;
    logic       idle;

    typedef struct {
        logic [5:0] data;
        logic [4:0] cnt;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    logic [4:0] exp_n0;
    logic [4:0] exp_n1;
    int checks;
    int errors;

    demux_destino #(
        .DATA_WIDTH (6),
        .DEST_BIT   (4),
        .CNT_WIDTH  (5)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .data_in        (data_in),
        .valid_in       (valid_in),
        .D0_almost_full (D0_almost_full),
        .D1_almost_full (D1_almost_full),
        .push_D0        (push_D0),
        .push_D1        (push_D1),
        .data_out_D0    (data_out_D0),
        .data_out_D1    (data_out_D1),
        .pause          (pause),
        .count_D0       (count_D0),
        .count_D1       (count_D1),
        .err_overflow   (err_overflow),
        .idle           (idle)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Present one word for one cycle; optionally register it as expected output
    task automatic send(input logic [5:0] w, input bit expect_out);
        exp_t e;
        data_in  = w;
        valid_in = 1'b1;
        if (expect_out) begin
            e.data = w;
            if (w[4]) begin
                exp_n1 = exp_n1 + 5'd1;
                e.cnt  = exp_n1;
                q1.push_back(e);
            end else begin
                exp_n0 = exp_n0 + 5'd1;
                e.cnt  = exp_n0;
                q0.push_back(e);
            end
        end
        step();
        valid_in = 1'b0;
    endtask

    // Monitor: compare every push against the scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            chk("push_exclusive", {31'd0, push_D0 & push_D1}, 32'd0);
            if (push_D0) begin
                if (q0.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL d0_unexpected: got push word %0h expected no push", data_out_D0);
                end else begin
                    e = q0.pop_front();
                    chk("d0_data", {26'd0, data_out_D0}, {26'd0, e.data});
                    chk("d0_count", {27'd0, count_D0}, {27'd0, e.cnt});
                end
            end
            if (push_D1) begin
                if (q1.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL d1_unexpected: got push word %0h expected no push", data_out_D1);
                end else begin
                    e = q1.pop_front();
                    chk("d1_data", {26'd0, data_out_D1}, {26'd0, e.data});
                    chk("d1_count", {27'd0, count_D1}, {27'd0, e.cnt});
                end
            end
        end
    end

    // Watchdog
    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0;
        errors = 0;
        exp_n0 = '0;
        exp_n1 = '0;
        reset          = 1'b1;
        data_in        = '0;
        valid_in       = 1'b0;
        D0_almost_full = 1'b0;
        D1_almost_full = 1'b0;

        // Reset state
        #3;
        chk("rst_push_D0", {31'd0, push_D0}, 32'd0);
        chk("rst_push_D1", {31'd0, push_D1}, 32'd0);
        chk("rst_pause", {31'd0, pause}, 32'd0);
        chk("rst_idle", {31'd0, idle}, 32'd1);
        chk("rst_counts", {22'd0, count_D0, count_D1}, 32'd0);
        step();
        reset = 1'b0;
        step();

        // Alternating routing
        send(6'h05, 1'b1);
        chk("alt_push_D0_lat", {31'd0, push_D0}, 32'd1);
        send(6'h15, 1'b1);
        chk("alt_push_D1_lat", {31'd0, push_D1}, 32'd1);
        chk("alt_push_D0_off", {31'd0, push_D0}, 32'd0);
        chk("alt_count_D0", {27'd0, count_D0}, 32'd1);
        chk("alt_count_D1", {27'd0, count_D1}, 32'd1);
        chk("alt_pause", {31'd0, pause}, 32'd0);
        step();

        // Head-of-line blocking then overflow
        D0_almost_full = 1'b1;
        send(6'h03, 1'b1);
        chk("hol_pause_one", {31'd0, pause}, 32'd1);
        send(6'h13, 1'b1);
        chk("hol_no_push", {30'd0, push_D0, push_D1}, 32'd0);
        chk("hol_pause_two", {31'd0, pause}, 32'd1);
        chk("hol_not_idle", {31'd0, idle}, 32'd0);
        step();
        chk("hol_still_blocked", {30'd0, push_D0, push_D1}, 32'd0);
        send(6'h07, 1'b0);
        chk("ovf_flag", {31'd0, err_overflow}, 32'd1);
        D0_almost_full = 1'b0;
        step();
        chk("hol_release_D0", {31'd0, push_D0}, 32'd1);
        chk("hol_release_data", {26'd0, data_out_D0}, 32'h03);
        chk("hol_pause_held", {31'd0, pause}, 32'd1);
        step();
        chk("hol_order_D1", {31'd0, push_D1}, 32'd1);
        chk("hol_order_data", {26'd0, data_out_D1}, 32'h13);
        chk("hol_pause_drop", {31'd0, pause}, 32'd0);
        step();
        chk("hol_idle", {31'd0, idle}, 32'd1);
        chk("ovf_sticky", {31'd0, err_overflow}, 32'd1);

        // Counter wrap: 32 words to D1, back to back
        for (int i = 0; i < 32; i++) begin
            send(6'h10 | 6'(i & 15), 1'b1);
            chk("wrap_push_D1", {31'd0, push_D1}, 32'd1);
        end
        step();
        chk("wrap_count_D1", {27'd0, count_D1}, 32'd2);
        chk("wrap_count_D0", {27'd0, count_D0}, 32'd2);

        // Reset mid-operation with a full buffer
        D0_almost_full = 1'b1;
        send(6'h01, 1'b0);
        send(6'h02, 1'b0);
        chk("mid_pause", {31'd0, pause}, 32'd1);
        #1;
        reset = 1'b1;
        #1;
        chk("mid_rst_push", {30'd0, push_D0, push_D1}, 32'd0);
        chk("mid_rst_data", {20'd0, data_out_D0, data_out_D1}, 32'd0);
        chk("mid_rst_pause", {31'd0, pause}, 32'd0);
        chk("mid_rst_counts", {22'd0, count_D0, count_D1}, 32'd0);
        chk("mid_rst_err", {31'd0, err_overflow}, 32'd0);
        chk("mid_rst_idle", {31'd0, idle}, 32'd1);
        q0.delete();
        q1.delete();
        exp_n0 = '0;
        exp_n1 = '0;
        step();
        reset = 1'b0;
        D0_almost_full = 1'b0;
        send(6'h11, 1'b1);
        chk("post_rst_push_D1", {31'd0, push_D1}, 32'd1);
        chk("post_rst_count_D1", {27'd0, count_D1}, 32'd1);
        step();
        step();
        chk("post_rst_idle", {31'd0, idle}, 32'd1);
        chk("sb_q0_drained", q0.size(), 32'd0);
        chk("sb_q1_drained", q1.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
